// File: rtl/capture_pkg.sv
// Shared types for the capture sequencer.
// Optional forced-trigger timeout is enabled with CAPTURE_TIMEOUT_EN.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  localparam int TIMEOUT_WIDTH = 32;

  function automatic logic is_active(input cap_state_t s);
    return (s == PRE_FILL) || (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/capture_counter.sv
// Loadable down-counter that steps on qualified samples.
// Flags zero and last (one remaining) for phase exits.
module capture_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-fill, arm, trigger, post-fill into circular RAM.
// Define CAPTURE_TIMEOUT_EN to build the forced-trigger timeout counter.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     valid,
  input  logic [SAMPLE_WIDTH-1:0]  dataIn,
  input  logic [ADDR_WIDTH-1:0]    pre_count,
  input  logic [ADDR_WIDTH-1:0]    post_count,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic                     run,
  output logic                     arm,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [SAMPLE_WIDTH-1:0]  wr_data,
  output logic [ADDR_WIDTH-1:0]    trig_addr,
  output logic [ADDR_WIDTH-1:0]    start_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     timed_out
);

  cap_state_t state, nxt;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] pre_lat;
  logic [ADDR_WIDTH-1:0] post_lat;
  logic [ADDR_WIDTH-1:0] taddr;
  logic [ADDR_WIDTH-1:0] pp_val;
  logic                  pp_load;
  logic                  pp_dec;
  logic                  pp_zero;
  logic                  pp_last;
  logic                  active;
  logic                  idle_like;
  logic                  run_hit;
  logic                  tmo_hit;
  logic                  trig;

  assign active    = is_active(state);
  assign idle_like = (state == IDLE) || (state == DONE);
  // A valid in the trigger cycle is itself the trigger sample
  assign taddr     = valid ? ptr : ptr - 1'b1;
  assign run_hit   = (state == ARMED) && run && !arm;
  assign trig      = run_hit || tmo_hit;
  assign pp_dec    = valid && ((state == PRE_FILL) || (state == POST));

  capture_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_phase_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (abort),
    .load    (pp_load),
    .load_val(pp_val),
    .dec     (pp_dec),
    .zero    (pp_zero),
    .last    (pp_last)
  );

`ifdef CAPTURE_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_lat;
  logic [TIMEOUT_WIDTH-1:0] tm_val;
  logic                     tm_load;
  logic                     tm_last;
  logic                     unused_tm_zero;

  // From IDLE/DONE the start cycle goes straight to ARMED before to_lat lands
  assign tm_val  = (state == PRE_FILL) ? to_lat : timeout;
  assign tm_load = (nxt == ARMED) && (state != ARMED);
  assign tmo_hit = (state == ARMED) && valid && tm_last
                 && (to_lat != '0);

  capture_counter #(
    .WIDTH(TIMEOUT_WIDTH)
  ) u_tmo_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (abort),
    .load    (tm_load),
    .load_val(tm_val),
    .dec     (valid && (state == ARMED)),
    .zero    (unused_tm_zero),
    .last    (tm_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_lat <= '0;
    end else if (abort) begin
      to_lat <= '0;
    end else if (start && idle_like) begin
      to_lat <= timeout;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    pp_load = 1'b0;
    pp_val  = pre_count;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            pp_load = 1'b1;
            nxt     = (pre_count != '0) ? PRE_FILL : ARMED;
          end
        end
        PRE_FILL: begin
          if (valid && pp_last) nxt = ARMED;
        end
        ARMED: begin
          if (trig) begin
            pp_load = 1'b1;
            pp_val  = post_lat;
            nxt     = POST;
          end
        end
        POST: begin
          if (pp_zero || (valid && pp_last)) nxt = DONE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      pre_lat    <= '0;
      post_lat   <= '0;
      arm        <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      ptr        <= '0;
      pre_lat    <= '0;
      post_lat   <= '0;
      arm        <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state <= nxt;
      arm   <= (nxt == ARMED) && (state != ARMED);
      busy  <= is_active(nxt);
      done  <= (nxt == DONE);
      wr_en <= valid && active;
      if (valid && active) begin
        wr_addr <= ptr;
        wr_data <= dataIn;
        ptr     <= ptr + 1'b1;
      end
      if (start && idle_like) begin
        pre_lat   <= pre_count;
        post_lat  <= post_count;
        timed_out <= 1'b0;
      end
      if (trig) begin
        trig_addr  <= taddr;
        start_addr <= taddr - pre_lat;
        timed_out  <= tmo_hit && !run_hit;
      end
    end
  end

endmodule
